// File: rtl/serial_operand_tx.sv
`default_nettype none
// ============================================================================
// Module      : serial_operand_tx
// Description : Parallel-to-serial operand transmitter. Accepts two operands
//               and a bit count over valid/ready, then streams one bit pair
//               per cycle, LSB first, with out_vld/out_last. A pause input
//               inserts bubbles without disturbing the bit sequence.
//               Optional feature macro: SERIAL_OPERAND_TX_SKID_EN adds a
//               one-entry skid register for zero-gap back-to-back streams.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_operand_tx #(
   parameter int WIDTH = 8,
   localparam int LW   = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [LW-1:0]    in_len,
   input  logic             pause,
   output logic             out_vld,
   output logic             out_a,
   output logic             out_b,
   output logic             out_last,
   output logic             busy
);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [WIDTH-1:0]  sh_a;
   logic [WIDTH-1:0]  sh_b;
   logic [LW-1:0]     cnt;
   logic              xfer;
   logic              beat;
   logic              final_beat;
   logic              load_in;

`ifdef SERIAL_OPERAND_TX_SKID_EN
   logic              skid_full;
   logic [WIDTH-1:0]  skid_a;
   logic [WIDTH-1:0]  skid_b;
   logic [LW-1:0]     skid_len;
   logic              load_skid;
   logic              skid_wr;
`endif

   // A zero length, or one beyond the operand width, means a full-width stream.
   function automatic logic [LW-1:0] eff_len(input logic [LW-1:0] len);
      if ((len == '0) || (len > LW'(WIDTH))) begin
         return LW'(WIDTH);
      end
      return len;
   endfunction

`ifdef SERIAL_OPERAND_TX_SKID_EN
   assign in_ready = !skid_full;
`else
   assign in_ready = (state_q == ST_IDLE);
`endif

   assign xfer       = in_valid && in_ready;
   assign final_beat = beat && (cnt == LW'(1));

   // Serial outputs are gated by the beat so bubbles and idle read as all-zero.
   assign out_vld  = beat;
   assign out_a    = beat && sh_a[0];
   assign out_b    = beat && sh_b[0];
   assign out_last = final_beat;
   assign busy     = (state_q == ST_SHIFT);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and datapath control decode.
   always_comb begin
      state_d = state_q;
      beat    = 1'b0;
      load_in = 1'b0;
`ifdef SERIAL_OPERAND_TX_SKID_EN
      load_skid = 1'b0;
      skid_wr   = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (xfer) begin
               load_in = 1'b1;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            beat = !pause;
            if (beat && (cnt == LW'(1))) begin
`ifdef SERIAL_OPERAND_TX_SKID_EN
               // Chain straight into the next transaction when one is waiting.
               if (skid_full) begin
                  load_skid = 1'b1;
               end else if (xfer) begin
                  load_in = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
`else
               state_d = ST_IDLE;
`endif
            end
`ifdef SERIAL_OPERAND_TX_SKID_EN
            // A transfer that is not consumed directly parks in the skid.
            if (xfer && !load_in) begin
               skid_wr = 1'b1;
            end
`endif
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Shift registers and remaining-beat counter; pause cycles hold everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         sh_a <= '0;
         sh_b <= '0;
         cnt  <= '0;
      end else if (load_in) begin
         sh_a <= in_a;
         sh_b <= in_b;
         cnt  <= eff_len(in_len);
`ifdef SERIAL_OPERAND_TX_SKID_EN
      end else if (load_skid) begin
         sh_a <= skid_a;
         sh_b <= skid_b;
         cnt  <= skid_len;
`endif
      end else if (beat) begin
         sh_a <= sh_a >> 1;
         sh_b <= sh_b >> 1;
         cnt  <= cnt - LW'(1);
      end
   end

`ifdef SERIAL_OPERAND_TX_SKID_EN
   // One-entry skid holding the next transaction while the current one shifts.
   always_ff @(posedge clk) begin
      if (rst) begin
         skid_full <= 1'b0;
         skid_a    <= '0;
         skid_b    <= '0;
         skid_len  <= '0;
      end else if (skid_wr) begin
         skid_full <= 1'b1;
         skid_a    <= in_a;
         skid_b    <= in_b;
         skid_len  <= eff_len(in_len);
      end else if (load_skid) begin
         skid_full <= 1'b0;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_operand_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_operand_tx
// Description : Self-checking bench for serial_operand_tx (WIDTH=8). Expected
//               beats are pushed to a scoreboard queue when a transaction is
//               offered and popped as the DUT emits valid beats.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_operand_tx;

   localparam int W  = 8;
   localparam int LW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_a = '0;
   logic [W-1:0]  in_b = '0;
   logic [LW-1:0] in_len = '0;
   logic          pause = 1'b0;
   logic          out_vld;
   logic          out_a;
   logic          out_b;
   logic          out_last;
   logic          busy;

   int            nchk = 0;
   int            nfail = 0;
   logic [2:0]    sb[$];

   serial_operand_tx #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_a     (in_a),
      .in_b     (in_b),
      .in_len   (in_len),
      .pause    (pause),
      .out_vld  (out_vld),
      .out_a    (out_a),
      .out_b    (out_b),
      .out_last (out_last),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   // Reference model: expected {a_bit, b_bit, last} per beat.
   function automatic void push_txn(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic [LW-1:0] len);
      int l;
      l = ((len == 0) || (int'(len) > W)) ? W : int'(len);
      for (int i = 0; i < l; i++) sb.push_back({a[i], b[i], (i == l - 1)});
   endfunction

   // Offer one transaction for a single clock; called just after a rising edge.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [LW-1:0] len, output logic rdy);
      in_valid = 1'b1; in_a = a; in_b = b; in_len = len;
      @(negedge clk); rdy = in_ready;
      @(posedge clk); #1; in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1; rst = 1'b0;
      @(negedge clk);
      nchk++;
      if ({in_ready, out_vld, out_a, out_b, out_last, busy} !== 6'b100000) begin
         nfail++; $display("FAIL reset_outputs: got %b expected 100000",
                           {in_ready, out_vld, out_a, out_b, out_last, busy});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_full_width();
      logic rdy; logic [2:0] e; int beats; logic [W-1:0] sum; logic carry; bit done;
      push_txn(8'hA5, 8'h3C, 4'd0);
      send(8'hA5, 8'h3C, 4'd0, rdy);
      nchk++;
      if (rdy !== 1'b1) begin nfail++; $display("FAIL full_ready: got %b expected 1", rdy); end
      beats = 0; sum = '0; carry = 1'b0; done = 0;
      for (int c = 0; c < 20 && !done; c++) begin
         @(negedge clk);
         if (out_vld) begin
            nchk++;
            if (sb.size() == 0) begin nfail++; $display("FAIL full_beat: extra beat"); end
            else begin
               e = sb.pop_front();
               if ({out_a, out_b, out_last} !== e) begin
                  nfail++; $display("FAIL full_beat%0d: got %b expected %b", beats, {out_a, out_b, out_last}, e);
               end
            end
            if (beats < W) sum[beats] = out_a ^ out_b ^ carry;
            carry = (out_a & out_b) | (carry & (out_a ^ out_b));
            beats++;
            if (out_last) done = 1;
         end
         @(posedge clk); #1;
      end
      nchk++;
      if (beats != 8) begin nfail++; $display("FAIL full_count: got %0d expected 8", beats); end
      nchk++;
      if (sum !== 8'hE1) begin nfail++; $display("FAIL full_sum: got %h expected e1", sum); end
      @(negedge clk);
      nchk++;
      if (busy !== 1'b0) begin nfail++; $display("FAIL full_busy_after: got %b expected 0", busy); end
      @(posedge clk); #1;
   endtask

   task automatic test_len();
      logic rdy; logic [2:0] e; int beats; bit done;
      logic [W-1:0] ta[2]; logic [W-1:0] tb_[2]; logic [LW-1:0] tl[2]; int tn[2];
      ta[0] = 8'hFF; tb_[0] = 8'h01; tl[0] = 4'd3;  tn[0] = 3;
      ta[1] = 8'h81; tb_[1] = 8'h7E; tl[1] = 4'd12; tn[1] = 8;
      for (int k = 0; k < 2; k++) begin
         push_txn(ta[k], tb_[k], tl[k]);
         send(ta[k], tb_[k], tl[k], rdy);
         beats = 0; done = 0;
         for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (out_vld) begin
               nchk++;
               if (sb.size() == 0) begin nfail++; $display("FAIL len%0d_beat: extra beat", k); end
               else begin
                  e = sb.pop_front();
                  if ({out_a, out_b, out_last} !== e) begin
                     nfail++; $display("FAIL len%0d_beat%0d: got %b expected %b", k, beats, {out_a, out_b, out_last}, e);
                  end
               end
               beats++;
               if (out_last) done = 1;
            end
            @(posedge clk); #1;
         end
         nchk++;
         if (beats != tn[k]) begin nfail++; $display("FAIL len%0d_count: got %0d expected %0d", k, beats, tn[k]); end
         @(negedge clk);
         nchk++;
         if (busy !== 1'b0) begin nfail++; $display("FAIL len%0d_busy_after: got %b expected 0", k, busy); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_pause();
      logic rdy; logic [2:0] e; int cyc; logic [9:0] vpat; bit done;
      push_txn(8'hA5, 8'h3C, 4'd0);
      send(8'hA5, 8'h3C, 4'd0, rdy);
      cyc = 0; vpat = '0; done = 0;
      for (int c = 1; c <= 20 && !done; c++) begin
         pause = (c == 2) || (c == 5);
         @(negedge clk);
         cyc = c;
         if (c <= 10) vpat[c-1] = out_vld;
         if (out_vld) begin
            nchk++;
            if (sb.size() == 0) begin nfail++; $display("FAIL pause_beat: extra beat"); end
            else begin
               e = sb.pop_front();
               if ({out_a, out_b, out_last} !== e) begin
                  nfail++; $display("FAIL pause_beat_c%0d: got %b expected %b", c, {out_a, out_b, out_last}, e);
               end
            end
            if (out_last) done = 1;
         end else if ({out_a, out_b, out_last} !== 3'b000) begin
            nchk++; nfail++; $display("FAIL pause_bubble_c%0d: got %b expected 000", c, {out_a, out_b, out_last});
         end
         @(posedge clk); #1;
      end
      pause = 1'b0;
      nchk++;
      if (vpat !== 10'b11111_01101) begin nfail++; $display("FAIL pause_vld_pattern: got %b expected 1111101101", vpat); end
      nchk++;
      if (cyc != 10) begin nfail++; $display("FAIL pause_cycles: got %0d expected 10", cyc); end
   endtask

   task automatic test_pause_last();
      logic rdy; logic [2:0] e; int cyc; bit done;
      push_txn(8'hA5, 8'h3C, 4'd3);
      send(8'hA5, 8'h3C, 4'd3, rdy);
      cyc = 0; done = 0;
      for (int c = 1; c <= 20 && !done; c++) begin
         pause = (c == 3) || (c == 4);
         @(negedge clk);
         cyc = c;
         if (pause) begin
            nchk++;
            if ({out_vld, out_last, busy} !== 3'b001) begin
               nfail++; $display("FAIL plast_hold_c%0d: got vld/last/busy %b expected 001", c, {out_vld, out_last, busy});
            end
         end
         if (out_vld) begin
            nchk++;
            if (sb.size() == 0) begin nfail++; $display("FAIL plast_beat: extra beat"); end
            else begin
               e = sb.pop_front();
               if ({out_a, out_b, out_last} !== e) begin
                  nfail++; $display("FAIL plast_beat_c%0d: got %b expected %b", c, {out_a, out_b, out_last}, e);
               end
            end
            if (out_last) done = 1;
         end
         @(posedge clk); #1;
      end
      pause = 1'b0;
      nchk++;
      if (cyc != 5) begin nfail++; $display("FAIL plast_cycles: got %0d expected 5", cyc); end
   endtask

   task automatic test_reset_mid();
      logic rdy; logic [2:0] e; int beats; bit done;
      push_txn(8'hA5, 8'h3C, 4'd0);
      send(8'hA5, 8'h3C, 4'd0, rdy);
      for (int c = 1; c <= 4; c++) begin
         if (c == 4) begin rst = 1'b1; in_valid = 1'b1; in_a = 8'hFF; in_b = 8'hFF; in_len = 4'd0; end
         @(negedge clk);
         nchk++;
         if (!out_vld || sb.size() == 0) begin
            nfail++; $display("FAIL rmid_beat%0d: got vld %b expected 1", c, out_vld);
         end else begin
            e = sb.pop_front();
            if ({out_a, out_b, out_last} !== e) begin
               nfail++; $display("FAIL rmid_beat%0d: got %b expected %b", c, {out_a, out_b, out_last}, e);
            end
         end
         @(posedge clk); #1;
      end
      rst = 1'b0; in_valid = 1'b0;
      sb.delete();
      @(negedge clk);
      nchk++;
      if ({in_ready, out_vld, out_last, busy} !== 4'b1000) begin
         nfail++; $display("FAIL rmid_after: got rdy/vld/last/busy %b expected 1000", {in_ready, out_vld, out_last, busy});
      end
      @(posedge clk); #1;
      push_txn(8'h0F, 8'hF0, 4'd2);
      send(8'h0F, 8'hF0, 4'd2, rdy);
      beats = 0; done = 0;
      for (int c = 0; c < 10 && !done; c++) begin
         @(negedge clk);
         if (out_vld) begin
            nchk++;
            if (sb.size() == 0) begin nfail++; $display("FAIL rmid_new: extra beat"); end
            else begin
               e = sb.pop_front();
               if ({out_a, out_b, out_last} !== e) begin
                  nfail++; $display("FAIL rmid_new%0d: got %b expected %b", beats, {out_a, out_b, out_last}, e);
               end
            end
            beats++;
            if (out_last) done = 1;
         end
         @(posedge clk); #1;
      end
      nchk++;
      if (beats != 2) begin nfail++; $display("FAIL rmid_new_count: got %0d expected 2", beats); end
   endtask

   task automatic test_back_to_back();
      logic [2:0] e; int beats; int gap; int hs; logic hs2_busy; logic [15:0] lmask; bit done;
      int exp_gap; logic exp_busy;
`ifdef SERIAL_OPERAND_TX_SKID_EN
      exp_gap = 0; exp_busy = 1'b1;
`else
      exp_gap = 1; exp_busy = 1'b0;
`endif
      push_txn(8'h12, 8'h34, 4'd0);
      push_txn(8'h56, 8'h78, 4'd0);
      in_valid = 1'b1; in_a = 8'h12; in_b = 8'h34; in_len = 4'd0;
      beats = 0; gap = 0; hs = 0; hs2_busy = 1'bx; lmask = '0; done = 0;
      for (int c = 0; c < 60 && !done; c++) begin
         @(negedge clk);
         if (in_valid && in_ready) begin
            hs++;
            if (hs == 2) hs2_busy = busy;
         end
         if (out_vld) begin
            nchk++;
            if (sb.size() == 0) begin nfail++; $display("FAIL b2b_beat: extra beat"); end
            else begin
               e = sb.pop_front();
               if ({out_a, out_b, out_last} !== e) begin
                  nfail++; $display("FAIL b2b_beat%0d: got %b expected %b", beats, {out_a, out_b, out_last}, e);
               end
            end
            if (beats < 16) lmask[beats] = out_last;
            beats++;
            if (beats >= 16) done = 1;
         end else if (beats > 0) begin
            gap++;
         end
         @(posedge clk); #1;
         if (hs == 1) begin in_a = 8'h56; in_b = 8'h78; end
         else if (hs >= 2) in_valid = 1'b0;
      end
      in_valid = 1'b0;
      nchk++;
      if (hs != 2) begin nfail++; $display("FAIL b2b_handshakes: got %0d expected 2", hs); end
      nchk++;
      if (gap != exp_gap) begin nfail++; $display("FAIL b2b_gap: got %0d expected %0d", gap, exp_gap); end
      nchk++;
      if (hs2_busy !== exp_busy) begin nfail++; $display("FAIL b2b_hs2_busy: got %b expected %b", hs2_busy, exp_busy); end
      nchk++;
      if (lmask !== 16'h8080) begin nfail++; $display("FAIL b2b_last_mask: got %h expected 8080", lmask); end
      nchk++;
      if (sb.size() != 0) begin nfail++; $display("FAIL b2b_leftover: got %0d expected 0", sb.size()); end
      @(negedge clk);
      nchk++;
      if (busy !== 1'b0) begin nfail++; $display("FAIL b2b_busy_after: got %b expected 0", busy); end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_full_width();
      test_len();
      test_pause();
      test_pause_last();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
